// File: rtl/rgb_led_sequencer_pkg.sv
// Shared types and cfg field layout for the RGB LED sequencer.
// Cfg word layout: {dur, duty_r, duty_g, duty_b}, dur in the MSBs.
package rgb_led_sequencer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int dur_lsb(input int pwm_w);
    return 3 * pwm_w;
  endfunction

  function automatic int duty_r_lsb(input int pwm_w);
    return 2 * pwm_w;
  endfunction

  function automatic int duty_g_lsb(input int pwm_w);
    return pwm_w;
  endfunction

  function automatic int duty_b_lsb(input int pwm_w);
    return 0 * pwm_w;
  endfunction

endpackage

// File: rtl/rgb_pwm.sv
// Three-channel PWM: shared counter, per-channel compare,
// registered outputs forced low while disabled or clearing.
module rgb_pwm
  import rgb_led_sequencer_pkg::*;
#(
  parameter int P_PWM_W = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               enable_i,
  input  logic               clear_i,
  input  logic [P_PWM_W-1:0] duty_r_i,
  input  logic [P_PWM_W-1:0] duty_g_i,
  input  logic [P_PWM_W-1:0] duty_b_i,
  output logic               led_r_o,
  output logic               led_g_o,
  output logic               led_b_o
);

  logic [P_PWM_W-1:0] cnt_q;
  logic [2:0]         raw;
  logic [2:0]         led_q;
  logic               on;

  assign raw = {cnt_q < duty_r_i,
                cnt_q < duty_g_i,
                cnt_q < duty_b_i};

  // clear marks a state change, so the next cycle is not RUN output
  assign on = enable_i & ~clear_i;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      led_q <= '0;
    end else begin
      if (clear_i)
        cnt_q <= '0;
      else if (enable_i)
        cnt_q <= cnt_q + 1'b1;
      led_q <= on ? raw : 3'b000;
    end
  end

  assign led_r_o = led_q[2];
  assign led_g_o = led_q[1];
  assign led_b_o = led_q[0];

endmodule

// File: rtl/rgb_led_sequencer.sv
// Steps the RGB LED through a programmable table of
// colour/duration entries on a prescaled tick.
module rgb_led_sequencer
  import rgb_led_sequencer_pkg::*;
#(
  parameter int P_STEPS    = 4,
  parameter int P_PRESCALE = 48000,
  parameter int P_DUR_W    = 8,
  parameter int P_PWM_W    = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_loop,
  input  logic                          i_cfg_we,
  input  logic [$clog2(P_STEPS)-1:0]    i_cfg_addr,
  input  logic [3*P_PWM_W+P_DUR_W-1:0]  i_cfg_data,
  output logic                          o_led_r,
  output logic                          o_led_g,
  output logic                          o_led_b,
  output logic                          o_busy,
  output logic                          o_done,
  output logic [$clog2(P_STEPS)-1:0]    o_step
);

  localparam int SW = $clog2(P_STEPS);
  localparam int PW = $clog2(P_PRESCALE);
  localparam int CW = 3*P_PWM_W + P_DUR_W;
  localparam int DUR_LSB = dur_lsb(P_PWM_W);
  localparam int R_LSB = duty_r_lsb(P_PWM_W);
  localparam int G_LSB = duty_g_lsb(P_PWM_W);
  localparam int B_LSB = duty_b_lsb(P_PWM_W);

  state_e             state_q;
  logic [SW-1:0]      step_q;
  logic [PW-1:0]      presc_q;
  logic [P_DUR_W-1:0] tick_cnt_q;
  logic               done_q;
  logic [CW-1:0]      table_q [P_STEPS];

  logic [CW-1:0]      act;
  logic [P_DUR_W-1:0] dur;
  logic [P_DUR_W-1:0] d_m1;
  logic run, tick, step_end, last;
  logic start_ok, finish, pwm_clr;

  assign act  = table_q[step_q];
  assign dur  = act[DUR_LSB +: P_DUR_W];
  assign d_m1 = (dur == '0) ? '0 : dur - 1'b1;

  assign run  = (state_q == ST_RUN);
  assign tick = run & (presc_q == PW'(P_PRESCALE-1));
  // >= so a shortened active entry ends on the next tick
  assign step_end = tick & (tick_cnt_q >= d_m1);
  assign last     = (step_q == SW'(P_STEPS-1));
  assign start_ok = ~run & i_start & ~i_stop;
  assign finish   = step_end & last & ~i_loop;
  assign pwm_clr  = start_ok | (run & (i_stop | finish));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      step_q     <= '0;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < P_STEPS; i++)
        table_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      if (i_cfg_we)
        table_q[i_cfg_addr] <= i_cfg_data;
      unique case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q    <= ST_RUN;
            step_q     <= '0;
            presc_q    <= '0;
            tick_cnt_q <= '0;
          end
        end
        ST_RUN: begin
          presc_q <= tick ? '0 : presc_q + 1'b1;
          if (i_stop) begin
            state_q    <= ST_IDLE;
            step_q     <= '0;
            presc_q    <= '0;
            tick_cnt_q <= '0;
          end else if (step_end) begin
            tick_cnt_q <= '0;
            step_q     <= step_q + 1'b1;
            if (finish) begin
              state_q <= ST_IDLE;
              step_q  <= '0;
              done_q  <= 1'b1;
            end
          end else if (tick) begin
            tick_cnt_q <= tick_cnt_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  rgb_pwm #(
    .P_PWM_W (P_PWM_W)
  ) u_pwm (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .enable_i (run),
    .clear_i  (pwm_clr),
    .duty_r_i (act[R_LSB +: P_PWM_W]),
    .duty_g_i (act[G_LSB +: P_PWM_W]),
    .duty_b_i (act[B_LSB +: P_PWM_W]),
    .led_r_o  (o_led_r),
    .led_g_o  (o_led_g),
    .led_b_o  (o_led_b)
  );

  assign o_busy = run;
  assign o_done = done_q;
  assign o_step = step_q;

endmodule
